// File: rtl/data_mem_mmio.sv
// Data-side memory for the single-cycle cpu: word RAM in the low half, TX FIFO/status/cycle MMIO in the high half.
// Optional cycle counter is built when DMEM_CYCLE_COUNTER_EN is defined.
module data_mem_mmio #(
  parameter int MEM_WORDS  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataAddr,
  input  logic [31:0] writeData,
  input  logic        we,
  output logic [31:0] readData,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [5:0] OFF_TXDATA = 6'd0;
  localparam logic [5:0] OFF_STATUS = 6'd1;
  localparam logic [5:0] OFF_CYCLE  = 6'd2;

  logic          sel_mmio;
  logic [5:0]    mmio_off;
  logic [AW-1:0] ram_idx;
  logic          unused_addr_bits;

  assign sel_mmio         = dataAddr[31];
  assign mmio_off         = dataAddr[7:2];
  assign ram_idx          = dataAddr[AW+1:2];
  assign unused_addr_bits = ^{dataAddr[30:8], dataAddr[1:0]};

  // RAM: never reset, so a store during a reset cycle still lands.
  logic [31:0] ram [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we && !sel_mmio) begin
      ram[ram_idx] <= writeData;
    end
  end

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    last_q, last_d;

  logic empty;
  logic full;
  logic tx_wr;
  logic status_wr;
  logic push;
  logic pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign tx_wr     = we && sel_mmio && (mmio_off == OFF_TXDATA);
  assign status_wr = we && sel_mmio && (mmio_off == OFF_STATUS);
  assign push      = tx_wr && !full && !reset;
  assign pop       = out_valid && out_ready;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    last_d     = last_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      last_d   = fifo_mem[rd_ptr_q];
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // full is the start-of-cycle value, so a same-cycle pop does not rescue the byte
    if (tx_wr && full) begin
      overflow_d = 1'b1;
    end else if (status_wr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_q     <= 8'h00;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      last_q     <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= writeData[7:0];
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? last_q : fifo_mem[rd_ptr_q];

  logic [31:0] cycle_val;

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_q, cycle_d;

  always_comb begin
    cycle_d = cycle_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = '0;
`endif

  logic [31:0] status_word;
  assign status_word = {27'b0, overflow_q, full, empty, 2'b00};

  always_comb begin
    readData = '0;
    if (!sel_mmio) begin
      readData = ram[ram_idx];
    end else begin
      unique case (mmio_off)
        OFF_STATUS: readData = status_word;
        OFF_CYCLE:  readData = cycle_val;
        default:    readData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: directed scenarios with literal expectations, then random traffic vs a queue model.
module tb_data_mem_mmio;

  localparam int MEMW  = 256;
  localparam int DEPTH = 8;
  localparam logic [31:0] A_TX  = 32'h8000_0000;
  localparam logic [31:0] A_ST  = 32'h8000_0004;
  localparam logic [31:0] A_CYC = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dataAddr = '0;
  logic [31:0] writeData = '0;
  logic        we = 1'b0;
  logic [31:0] readData;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  data_mem_mmio #(.MEM_WORDS(MEMW), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .dataAddr  (dataAddr),
    .writeData (writeData),
    .we        (we),
    .readData  (readData),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model
  bit          mvalid = 1'b0;
  byte unsigned q[$];
  bit          ovf = 1'b0;
  logic [7:0]  last = 8'h00;
  logic [31:0] ram_m [MEMW];
  bit          known [MEMW];
  logic [31:0] cyc_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    return {27'b0, ovf, (q.size() == DEPTH), (q.size() == 0), 2'b00};
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int off;
    if (!a[31]) return ram_m[(a >> 2) % MEMW];
    off = (a >> 2) & 63;
    if (off == 1) return model_status();
    if (off == 2) begin
`ifdef DMEM_CYCLE_COUNTER_EN
      return cyc_m;
`else
      return 32'h0;
`endif
    end
    return 32'h0;
  endfunction

  task automatic compare_model();
    int idx;
    if (!mvalid) return;
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    chk("out_data", {24'b0, out_data}, {24'b0, (q.size() != 0) ? q[0] : last});
    idx = (dataAddr >> 2) % MEMW;
    if (dataAddr[31] || known[idx]) chk("read_data", readData, model_read(dataAddr));
  endtask

  task automatic model_update();
    int  idx;
    int  off;
    bit  was_full;
    bit  do_pop;
    bit  do_push;
    idx = (dataAddr >> 2) % MEMW;
    off = (dataAddr >> 2) & 63;
    if (we && !dataAddr[31]) begin
      ram_m[idx] = writeData;
      known[idx] = 1'b1;
    end
    if (reset) begin
      q.delete();
      ovf    = 1'b0;
      last   = 8'h00;
      cyc_m  = '0;
      mvalid = 1'b1;
    end else begin
      was_full = (q.size() == DEPTH);
      do_pop   = (q.size() != 0) && out_ready;
      do_push  = 1'b0;
      cyc_m    = cyc_m + 32'd1;
      if (we && dataAddr[31] && off == 0) begin
        if (was_full) ovf = 1'b1;
        else do_push = 1'b1;
      end
      if (we && dataAddr[31] && off == 1) ovf = 1'b0;
      if (do_pop) last = q.pop_front();
      if (do_push) q.push_back(writeData[7:0]);
    end
  endtask

  // Inputs are set after posedge+1, checked at negedge, model advanced at posedge.
  task automatic cycle();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic peek(input logic [31:0] a);
    dataAddr = a;
    we = 1'b0;
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    dataAddr = a;
    writeData = d;
    we = 1'b1;
    cycle();
    we = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_cyc;
    int sel;
    int off;
    int ready_pct;

    // Reset and counter
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    peek(A_ST);
    chk("lit_status_reset", readData, 32'h0000_0004);
    chk("lit_valid_reset", {31'b0, out_valid}, 32'h0);
    chk("lit_data_reset", {24'b0, out_data}, 32'h0);
    repeat (10) cycle();
    peek(A_CYC);
`ifdef DMEM_CYCLE_COUNTER_EN
    exp_cyc = 32'h0000_000A;
`else
    exp_cyc = 32'h0;
`endif
    chk("lit_cycle_10", readData, exp_cyc);

    // RAM store, load and alias
    store(32'h0000_0000, 32'h0000_01FE);
    peek(32'h0000_0000);
    chk("lit_ram_w0", readData, 32'h0000_01FE);
    peek(32'h0000_0402);
    chk("lit_ram_alias", readData, 32'h0000_01FE);

    // FIFO basic
    out_ready = 1'b0;
    chk("lit_valid_before_push", {31'b0, out_valid}, 32'h0);
    store(A_TX, 32'h41);
    chk("lit_valid_after_push", {31'b0, out_valid}, 32'h1);
    store(A_TX, 32'h42);
    store(A_TX, 32'h43);
    cycle();
    chk("lit_head_held", {24'b0, out_data}, 32'h41);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lit_drain_abc", {24'b0, out_data}, 32'h41 + k);
      cycle();
    end
    chk("lit_valid_drained", {31'b0, out_valid}, 32'h0);
    peek(A_ST);
    chk("lit_status_drained", readData, 32'h0000_0004);

    // Full and overflow
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) store(A_TX, k);
    peek(A_ST);
    chk("lit_status_ovf", readData, 32'h0000_0018);
    store(A_ST, 32'hFFFF_FFFF);
    peek(A_ST);
    chk("lit_status_ovf_clr", readData, 32'h0000_0008);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("lit_drain_full", {24'b0, out_data}, k);
      cycle();
    end
    chk("lit_valid_after_full", {31'b0, out_valid}, 32'h0);

    // Full with simultaneous pop and push: push dropped
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) store(A_TX, 32'h10 + k);
    out_ready = 1'b1;
    store(A_TX, 32'h99);
    peek(A_ST);
    chk("lit_status_full_pop_push", readData, 32'h0000_0010);
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("lit_drain_after_drop", {24'b0, out_data}, 32'h11 + k);
      cycle();
    end
    peek(A_ST);
    chk("lit_status_empty_ovf", readData, 32'h0000_0014);
    store(A_ST, 32'h0);
    peek(A_ST);
    chk("lit_status_cleared", readData, 32'h0000_0004);

    // Count 3 with concurrent push and pop, across pointer wrap
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) store(A_TX, 32'hA0 + k);
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      dataAddr = A_TX;
      writeData = 32'hB0 + k;
      we = 1'b1;
      #1;
      chk("lit_stream_order", {24'b0, out_data}, (k < 3) ? (32'hA0 + k) : (32'hB0 + k - 3));
      cycle();
    end
    we = 1'b0;
    peek(A_ST);
    chk("lit_status_count3", readData, 32'h0000_0000);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lit_stream_tail", {24'b0, out_data}, 32'hB9 + k);
      cycle();
    end

    // Reset mid-operation
    out_ready = 1'b0;
    store(32'h0000_0010, 32'hCAFE_F00D);
    for (int k = 0; k < 5; k++) store(A_TX, 32'h60 + k);
    reset = 1'b1;
    dataAddr = 32'h0000_0020;
    writeData = 32'h1234_5678;
    we = 1'b1;
    cycle();
    dataAddr = A_TX;
    writeData = 32'h55;
    cycle();
    reset = 1'b0;
    we = 1'b0;
    chk("lit_valid_post_reset", {31'b0, out_valid}, 32'h0);
    chk("lit_data_post_reset", {24'b0, out_data}, 32'h0);
    peek(A_ST);
    chk("lit_status_post_reset", readData, 32'h0000_0004);
    peek(32'h0000_0010);
    chk("lit_ram_persist", readData, 32'hCAFE_F00D);
    peek(32'h0000_0020);
    chk("lit_ram_reset_store", readData, 32'h1234_5678);

    // Random traffic against the model
    ready_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) ready_pct = $urandom_range(10, 95);
      reset = ($urandom_range(0, 299) == 0);
      sel = $urandom_range(0, 7);
      if (sel < 2) begin
        dataAddr = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3) | ($urandom_range(0, 3) << 10);
      end else begin
        case (sel)
          2, 3, 4: off = 0;
          5:       off = 1;
          6:       off = 2;
          default: off = $urandom_range(3, 63);
        endcase
        dataAddr = 32'h8000_0000 | ($urandom & 32'h7FFF_FF00) | (off << 2) | $urandom_range(0, 3);
      end
      writeData = $urandom;
      we = ($urandom_range(0, 99) < ((sel == 5) ? 10 : 60));
      out_ready = ($urandom_range(0, 99) < ready_pct);
      cycle();
    end
    reset = 1'b0;
    we = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Data-side memory responder for the single-cycle `cpu`, serving `dataAddr`/`writeData`/`we` and returning `readData` in the same cycle. Low half of the address space is a word-addressed RAM. High half holds memory-mapped I/O: a byte-wide transmit FIFO drained through a valid/ready port, a status register and an optional cycle counter. The block sits between `cpu` and the board-level output sink.

## Interface
Parameters:
- `MEM_WORDS`, 256: RAM depth in 32-bit words; power of two, 16..4096.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, 2..16.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: reset is synchronous and active-high.
- `dataAddr`, in, 32: byte address from the CPU.
- `writeData`, in, 32: store data.
- `we`, in, 1: store strobe, sampled at the rising edge.
- `readData`, out, 32: load data, combinational from `dataAddr`.
- `out_data`, out, 8: FIFO head byte.
- `out_valid`, out, 1: FIFO not empty.
- `out_ready`, in, 1: sink accepts `out_data` this cycle.

## Operation
- Decode: `dataAddr[31]`=0 selects RAM; `dataAddr[31]`=1 selects MMIO. `dataAddr[1:0]` is ignored for both regions, so all accesses are whole words.
- RAM:
  - Index = `dataAddr[log2(MEM_WORDS)+1:2]`; upper address bits alias (wrap).
  - Read is combinational.
  - Write on the edge when `we`=1.
  - The array is not reset; contents persist across `reset`.
- MMIO map, decoded on `dataAddr[7:2]`, with `dataAddr[30:8]` ignored:
  - 0x8000_0000 TXDATA: write pushes `writeData[7:0]`; read returns 0.
  - 0x8000_0004 STATUS: read returns {27'b0, `overflow`, `full`, `empty`, 2'b0}, i.e. bit2=`empty`, bit3=`full`, bit4=`overflow`. Any write clears `overflow`.
  - 0x8000_0008 CYCLE: see Configuration. Writes are ignored.
  - Any other MMIO offset: reads return 0; writes are ignored.
- FIFO:
  - Circular buffer with read pointer, write pointer and a count of width log2(FIFO_DEPTH)+1.
  - Push = `we` & TXDATA selected & !`full`. `full` is the value registered at the start of the cycle.
  - Push while `full` drops the byte and sets sticky `overflow`. This holds even if a pop happens in the same cycle.
  - Pop = `out_valid` & `out_ready`.
  - Push and pop in the same cycle leave the count unchanged; both pointers advance and wrap modulo FIFO_DEPTH.
  - No bypass: a push into an empty FIFO is visible on `out_valid` on the next cycle.
  - `out_data` = entry at the read pointer. When empty, `out_data` holds the last popped value (0 after reset).
- Reset (any cycle, including mid-transfer):
  - Pointers and count go to 0, so the FIFO is empty. Queued bytes are discarded.
  - `overflow`=0, cycle counter=0.
  - A store presented during the reset cycle is dropped for MMIO but still written to RAM.

## Timing
- Load latency 0: `readData` follows `dataAddr` combinationally and is valid within the same CPU cycle.
- Store effect is visible to a load on the next cycle.
- Output values after reset: `out_valid`=0, `out_data`=0x00. `readData` is the RAM word at `dataAddr`, or the MMIO value with STATUS = 0x0000_0004.
- `empty`/`full`/`out_valid` are registered and change only on edges.
- Sink handshake:
  - `out_data` must stay stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` never drops without a pop or a reset.
- Throughput: one push and one pop per cycle.

## Configuration
- `DMEM_CYCLE_COUNTER_EN` defined:
  - 32-bit counter; set to 0 during a `reset` cycle; otherwise +1 on every edge, wrapping 0xFFFF_FFFF→0.
  - CYCLE read returns the current counter value (edges since reset deasserted).
- Undefined: no counter register is built, and CYCLE reads return 0.

## Test plan
- RAM: store 0x0000_01FE to 0x0000_0000, then load 0x0000_0000 → `readData`=0x0000_01FE. Load 0x0000_0402 with MEM_WORDS=256 → aliases word 0 → `readData`=0x0000_01FE.
- FIFO basic: `out_ready`=0; push 0x41, 0x42, 0x43 → `out_valid`=1 one cycle after the first push and `out_data`=0x41 held. Raise `out_ready` → 0x41, 0x42, 0x43 on consecutive cycles, then `out_valid`=0 and STATUS=0x0000_0004.
- Full/overflow: `out_ready`=0; 9 pushes 0x00..0x08 → STATUS=0x0000_0018 and 0x08 is lost. Write to STATUS → 0x0000_0008. Drain → 0x00..0x07 in order.
- Simultaneous events:
  - With the FIFO full and a pop in the same cycle, a push is dropped and `overflow` is set.
  - With FIFO count=3 and `out_ready`=1, a push leaves the count at 3; after both pointers wrap past FIFO_DEPTH, data order is preserved.
- Reset mid-operation: with 5 bytes queued, assert `reset` for one cycle → `out_valid`=0, STATUS=0x0000_0004; a RAM word written before the reset still reads back unchanged.
- Counter: with `DMEM_CYCLE_COUNTER_EN`, release reset and read CYCLE after 10 edges → 0x0000_000A. Without the macro → 0.
